load_hazard_scoreboard: RTL

- Issue-stage scoreboard for the 4-slot VLIW bundle (IXU1, IXU2, LSU, branch) when memory latency exceeds 1 cycle.
- ALU results still reach execute through the WB→EX forwarding unit. Load data is not ready in time for that path, so this block tracks in-flight load destinations with per-register countdowns.
- Stalls bundle issue until every source and destination register of the waiting bundle is free. Sits between decode and the execute pipeline registers.

---
 rtl/load_hazard_scoreboard.sv | 106 ++++++++++
 1 files changed

// File: rtl/load_hazard_scoreboard.sv
// Issue-stage load-use/WAW scoreboard for the 4-slot VLIW bundle.
// Per-register countdowns track in-flight load destinations until their data is forwardable.
module load_hazard_scoreboard #(
  parameter int unsigned LOAD_LATENCY = 3,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic        ext_stall,
  input  logic [4:0]  ixu1_rs1,
  input  logic [4:0]  ixu1_rs2,
  input  logic [4:0]  ixu2_rs1,
  input  logic [4:0]  ixu2_rs2,
  input  logic [4:0]  lsu_rs1,
  input  logic [4:0]  lsu_rs2,
  input  logic [4:0]  branch_rs1,
  input  logic [4:0]  branch_rs2,
  input  logic [4:0]  ixu1_rd,
  input  logic [4:0]  ixu2_rd,
  input  logic [4:0]  lsu_rd,
  input  logic        ixu1_nop,
  input  logic        ixu2_nop,
  input  logic        lsu_nop,
  input  logic        branch_nop,
  input  logic        lsu_is_load,
  output logic        stall,
  output logic        issue_fire,
  output logic [31:0] busy_mask,
  output logic [31:0] stall_cycles
);

  localparam logic [CNT_W-1:0] LoadInit = CNT_W'(LOAD_LATENCY - 1);

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [31:0]      busy;
  logic [31:0]      stall_cycles_q;
  logic             hz;
  logic             set_load;

  always_comb begin
    busy = '0;
    for (int r = 1; r < 32; r++) begin
      busy[r] = (cnt_q[r] != '0);
    end
  end

  // Sources and live destinations of every non-nop slot must be idle.
  always_comb begin
    hz = 1'b0;
    if (!ixu1_nop) begin
      hz = hz | busy[ixu1_rs1] | busy[ixu1_rs2] | ((ixu1_rd != 5'd0) & busy[ixu1_rd]);
    end
    if (!ixu2_nop) begin
      hz = hz | busy[ixu2_rs1] | busy[ixu2_rs2] | ((ixu2_rd != 5'd0) & busy[ixu2_rd]);
    end
    if (!lsu_nop) begin
      hz = hz | busy[lsu_rs1] | busy[lsu_rs2] | ((lsu_rd != 5'd0) & busy[lsu_rd]);
    end
    if (!branch_nop) begin
      hz = hz | busy[branch_rs1] | busy[branch_rs2];
    end
  end

  always_comb begin
    stall      = rst_n & issue_valid & hz;
    issue_fire = rst_n & issue_valid & ~hz & ~ext_stall;
  end

  assign set_load = issue_fire & lsu_is_load & ~lsu_nop & (lsu_rd != 5'd0);

  // Set wins over decrement; everything holds under ext_stall.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
      if (!ext_stall && cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
      if (set_load && lsu_rd == 5'(r)) begin
        cnt_d[r] = LoadInit;
      end
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
      stall_cycles_q <= '0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      if (stall && stall_cycles_q != 32'hFFFF_FFFF) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
    end
  end

  assign busy_mask    = busy;
  assign stall_cycles = stall_cycles_q;

endmodule
